// File: rtl/core_lsu.sv
// core_lsu: single-outstanding load/store unit on a req/gnt/rvalid data bus.
// Optional macro CORE_LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error completions.
module core_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [4:0]  RD,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic [4:0]  o_rd,
    output logic        o_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // Only the load flavour survives acceptance; stores are fully described by mem_we/be/wdata.
    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
    } ld_op_t;

    state_t      state;
    ld_op_t      ld_q;
    logic [1:0]  off_q;
    logic [15:0] cnt;

    logic [7:0]  op_vec;
    logic        op_ok;
    logic        is_store;
    logic        misalign;
    logic        timeout_hit;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign i_ready  = (state == IDLE);
    assign op_vec   = {I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB};
    assign op_ok    = $onehot(op_vec);
    assign is_store = I_SB | I_SH | I_SW;

`ifdef CORE_LSU_MISALIGN_TRAP_EN
    assign misalign = ((I_LH | I_LHU | I_SH) & ADDR[0]) |
                      ((I_LW | I_SW) & (ADDR[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // cnt starts at 0 on REQ entry, so TIMEOUT cycles in REQ+RESP end on cnt == TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == 16'(TIMEOUT - 1));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = WDATA;
        if (I_SB) begin
            be_c    = 4'b0001 << ADDR[1:0];
            wdata_c = {4{WDATA[7:0]}};
        end else if (I_SH) begin
            be_c    = ADDR[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{WDATA[15:0]}};
        end
    end

    assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = 32'h0;
        if (ld_q.lb)
            load_data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_q.lbu)
            load_data = {24'h0, byte_sel};
        else if (ld_q.lh)
            load_data = {{16{half_sel[15]}}, half_sel};
        else if (ld_q.lhu)
            load_data = {16'h0, half_sel};
        else if (ld_q.lw)
            load_data = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ld_q      <= '0;
            off_q     <= 2'b00;
            cnt       <= 16'h0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
            o_rdata   <= 32'h0;
            o_rd      <= 5'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        ld_q  <= {I_LB, I_LH, I_LW, I_LBU, I_LHU};
                        off_q <= ADDR[1:0];
                        o_rd  <= RD;
                        if (!op_ok || misalign) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_err   <= 1'b1;
                            o_rdata <= 32'h0;
                        end else begin
                            state     <= REQ;
                            cnt       <= 16'h0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {ADDR[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 16'd1;
                    // Timeout wins over a same-cycle grant so the error window is exact.
                    if (timeout_hit) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        o_valid <= 1'b1;
                        o_err   <= 1'b1;
                        o_rdata <= 32'h0;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_err   <= 1'b0;
                            o_rdata <= 32'h0;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    cnt <= cnt + 16'd1;
                    if (timeout_hit) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_err   <= 1'b1;
                        o_rdata <= 32'h0;
                    end else if (mem_rvalid) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_err   <= 1'b0;
                        o_rdata <= load_data;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    o_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: scoreboard bench for core_lsu; bus fields checked while driving, completions checked on o_valid.
module tb_core_lsu;
    localparam int TO = 4;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int LB = 0, LH = 1, LW = 2, LBU = 3, LHU = 4, SB = 5, SH = 6, SW = 7;
    localparam logic [7:0] M_LB = 8'h01, M_LH = 8'h02, M_LW = 8'h04, M_LBU = 8'h08;
    localparam logic [7:0] M_LHU = 8'h10, M_SB = 8'h20, M_SH = 8'h40, M_SW = 8'h80;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_valid = 1'b0, i_ready;
    logic        I_LB = 0, I_LH = 0, I_LW = 0, I_LBU = 0, I_LHU = 0, I_SB = 0, I_SH = 0, I_SW = 0;
    logic [31:0] ADDR = '0, WDATA = '0;
    logic [4:0]  RD = '0;
    logic        o_valid, o_err, mem_req, mem_we;
    logic [31:0] o_rdata, mem_addr, mem_wdata;
    logic [4:0]  o_rd;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int n_chk = 0, n_fail = 0;

    core_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
        .I_LB(I_LB), .I_LH(I_LH), .I_LW(I_LW), .I_LBU(I_LBU), .I_LHU(I_LHU),
        .I_SB(I_SB), .I_SH(I_SH), .I_SW(I_SW),
        .ADDR(ADDR), .WDATA(WDATA), .RD(RD),
        .o_valid(o_valid), .o_rdata(o_rdata), .o_rd(o_rd), .o_err(o_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic m_mis(input logic [7:0] op, input logic [31:0] a);
        return TRAP_EN && (((op[LH] | op[LHU] | op[SH]) & a[0]) |
                           ((op[LW] | op[SW]) & (a[1:0] != 2'b00)));
    endfunction

    function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] a);
        if (op[SB]) begin
            case (a[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (op[SH]) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [7:0] op, input logic [31:0] d);
        if (op[SB]) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (op[SH]) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0: b = d[7:0];
            2'd1: b = d[15:8];
            2'd2: b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        if (op[LB])  return {{24{b[7]}}, b};
        if (op[LBU]) return {24'h0, b};
        if (op[LH])  return {{16{h[15]}}, h};
        if (op[LHU]) return {16'h0, h};
        return d;
    endfunction

    // Every o_valid must match the oldest expected completion, including its cycle.
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) chk("unexpected_o_valid", 32'(o_valid), 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("o_valid_cycle", cyc, e.cyc);
                chk("o_rdata", o_rdata, e.rdata);
                chk("o_rd", 32'(o_rd), 32'(e.rd));
                chk("o_err", 32'(o_err), 32'(e.err));
            end
        end
    end

    task automatic drive_op(input logic [7:0] op);
        {I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB} = op;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    // g: REQ cycles before gnt; r: RESP cycles before rvalid (<0 means rvalid never comes).
    task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int g, input int r, input logic [31:0] rdata);
        exp_t e;
        int   k, span;
        logic ld, bad, tmo;
        ld   = |op[4:0];
        bad  = ($countones(op) != 1) || m_mis(op, addr);
        span = ld ? ((r < 0) ? 1000 : 2 + g + r) : 1 + g;
        tmo  = !bad && (span >= TO);
        chk("i_ready_idle", 32'(i_ready), 32'd1);
        drive_op(op);
        ADDR = addr; WDATA = wd; RD = rd; i_valid = 1'b1;
        k = cyc;
        e.rd    = rd;
        e.err   = bad || tmo;
        e.rdata = (bad || tmo || !ld) ? 32'h0 : m_load(op, addr, rdata);
        e.cyc   = bad ? k + 1 : tmo ? k + 1 + TO : ld ? k + 3 + g + r : k + 2 + g;
        sb.push_back(e);
        @(posedge clk); #1;
        i_valid = 1'b0;
        drive_op(8'h00);
        if (bad) chk("no_mem_req", 32'(mem_req), 32'd0);
        else begin
            chk("i_ready_busy", 32'(i_ready), 32'd0);
            for (int i = 0; i <= g && i < TO; i++) begin
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_we", 32'(mem_we), 32'(!ld));
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_be", 32'(mem_be), 32'(m_be(op, addr)));
                if (!ld) chk("mem_wdata", mem_wdata, m_wd(op, wd));
                if (i == g) begin
                    mem_gnt = 1'b1; mem_rvalid = 1'b0;
                end else begin
                    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0000 | 32'(i);
                end
                @(posedge clk); #1;
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            chk("mem_req_drop", 32'(mem_req), 32'd0);
            if (ld && !tmo) begin
                for (int i = 0; i < r; i++) begin
                    @(posedge clk); #1;
                end
                mem_rvalid = 1'b1; mem_rdata = rdata;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
        drain("completion_seen");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_err", 32'(o_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_o_rdata", o_rdata, 32'd0);
        chk("rst_o_rd", 32'(o_rd), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);

        // Misaligned word store, then the aligned one.
        access(M_SW, 32'h0000_0007, 32'h1122_3344, 5'd1, 0, 0, 32'h0);
        access(M_SW, 32'h0000_0004, 32'h0557_D0BE, 5'd2, 0, 0, 32'h0);
        // Byte store with a held request (rvalid noise during REQ is ignored).
        access(M_SB, 32'h0000_0013, 32'h0000_00A5, 5'd3, 2, 0, 32'h0);
        access(M_SH, 32'h0000_0002, 32'hCAFE_1234, 5'd4, 1, 0, 32'h0);
        access(M_SH, 32'h0000_0101, 32'h0000_BEEF, 5'd4, 0, 0, 32'h0);
        // Load extension.
        access(M_LBU, 32'h0000_0021, 32'h0, 5'd7, 0, 0, 32'h1234_8056);
        access(M_LB,  32'h0000_0021, 32'h0, 5'd7, 0, 0, 32'h1234_8056);
        access(M_LH,  32'h0000_0022, 32'h0, 5'd7, 0, 0, 32'h8001_0000);
        access(M_LHU, 32'h0000_0022, 32'h0, 5'd7, 1, 1, 32'h8001_0000);
        access(M_LB,  32'h0000_0043, 32'h0, 5'd11, 0, 1, 32'h7F00_0000);
        access(M_LW,  32'h0000_0048, 32'h0, 5'd12, 0, 0, 32'hA5A5_0F0F);
        access(M_LHU, 32'h0000_0031, 32'h0, 5'd13, 0, 0, 32'hFEDC_BA98);

        // Load granted but never answered; a late rvalid must be ignored.
        access(M_LW, 32'h0000_0100, 32'h0, 5'd9, 0, -1, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("late_rvalid_ready", 32'(i_ready), 32'd1);
        chk("late_rvalid_no_valid", 32'(o_valid), 32'd0);
        // Store never granted.
        access(M_SW, 32'h0000_0200, 32'h1357_9BDF, 5'd10, 6, 0, 32'h0);

        // Reset while waiting in RESP.
        chk("pre_rst_ready", 32'(i_ready), 32'd1);
        drive_op(M_LW); ADDR = 32'h40; RD = 5'd3; i_valid = 1'b1;
        @(posedge clk); #1;
        drive_op(8'h00); i_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_ready", 32'(i_ready), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("midrst_no_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        chk("midrst_no_valid2", 32'(o_valid), 32'd0);
        access(M_LW, 32'h0000_0000, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);

        // Bad op encodings: two flags, then none.
        access(M_LW | M_SW, 32'h0000_0010, 32'h0, 5'd6, 0, 0, 32'h0);
        access(8'h00, 32'h0000_0010, 32'h0, 5'd8, 0, 0, 32'h0);
        access(M_SB, 32'h0000_0011, 32'h0000_003C, 5'd14, 0, 0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
